// File: rtl/brc_seq.sv
// Multi-cycle branch comparator: compares operands CHUNK bits per cycle from
// the MSB chunk down, terminating early on the first differing chunk.
module brc_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_br_un,
    input  logic [2:0]       i_br_op,
    input  logic [WIDTH-1:0] i_rs1_data,
    input  logic [WIDTH-1:0] i_rs2_data,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_brc_less,
    output logic             o_brc_equal,
    output logic             o_br_taken,
    output logic             o_illegal
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             un_q, un_d;
    logic [2:0]       op_q, op_d;
    logic [KW-1:0]    k_q, k_d;
    logic             less_q, less_d;
    logic             equal_q, equal_d;
    logic             taken_q, taken_d;
    logic             illegal_q, illegal_d;

    logic [CHUNK-1:0] a_chunk, b_chunk;
    logic             chunk_lt, chunk_eq;

    // Returns {taken, illegal}; signedness is already folded into less.
    function automatic logic [1:0] decode(input logic [2:0] op,
                                          input logic lt_f,
                                          input logic eq_f);
        logic [1:0] r;
        case (op)
            3'b000:          r = {eq_f,  1'b0};
            3'b001:          r = {~eq_f, 1'b0};
            3'b100, 3'b110:  r = {lt_f,  1'b0};
            3'b101, 3'b111:  r = {~lt_f, 1'b0};
            default:         r = 2'b01;
        endcase
        return r;
    endfunction

    // Current chunk; signed mode biases the sign bit of the top chunk only.
    always_comb begin
        a_chunk = CHUNK'(a_q >> (32'(k_q) * CHUNK));
        b_chunk = CHUNK'(b_q >> (32'(k_q) * CHUNK));
        if (un_q && (k_q == K_TOP)) begin
            a_chunk[CHUNK-1] = ~a_chunk[CHUNK-1];
            b_chunk[CHUNK-1] = ~b_chunk[CHUNK-1];
        end
        chunk_lt = (a_chunk < b_chunk);
        chunk_eq = (a_chunk == b_chunk);
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        un_d      = un_q;
        op_d      = op_q;
        k_d       = k_q;
        less_d    = less_q;
        equal_d   = equal_q;
        taken_d   = taken_q;
        illegal_d = illegal_q;

        if (i_flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_valid) begin
                        a_d     = i_rs1_data;
                        b_d     = i_rs2_data;
                        un_d    = i_br_un;
                        op_d    = i_br_op;
                        k_d     = K_TOP;
                        state_d = CMP;
                    end
                end
                CMP: begin
                    if (!chunk_eq || (k_q == '0)) begin
                        less_d                 = chunk_lt;
                        equal_d                = chunk_eq;
                        {taken_d, illegal_d}   = decode(op_q, chunk_lt, chunk_eq);
                        state_d                = DONE;
                    end else begin
                        k_d = k_q - KW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            un_q      <= 1'b0;
            op_q      <= 3'b000;
            k_q       <= K_TOP;
            less_q    <= 1'b0;
            equal_q   <= 1'b0;
            taken_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            un_q      <= un_d;
            op_q      <= op_d;
            k_q       <= k_d;
            less_q    <= less_d;
            equal_q   <= equal_d;
            taken_q   <= taken_d;
            illegal_q <= illegal_d;
        end
    end

    assign o_ready     = (state_q == IDLE);
    assign o_valid     = (state_q == DONE);
    assign o_brc_less  = less_q;
    assign o_brc_equal = equal_q;
    assign o_br_taken  = taken_q;
    assign o_illegal   = illegal_q;

endmodule

// File: tb/tb_brc_seq.sv
// Directed bench for brc_seq (WIDTH=32, CHUNK=8) with hand-computed results.
module tb_brc_seq;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic        i_br_un;
    logic [2:0]  i_br_op;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic        o_brc_less;
    logic        o_brc_equal;
    logic        o_br_taken;
    logic        o_illegal;

    int total = 0;
    int bad   = 0;

    brc_seq #(.WIDTH(32), .CHUNK(8)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_br_un     (i_br_un),
        .i_br_op     (i_br_op),
        .i_rs1_data  (i_rs1_data),
        .i_rs2_data  (i_rs2_data),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_brc_less  (o_brc_less),
        .o_brc_equal (o_brc_equal),
        .o_br_taken  (o_br_taken),
        .o_illegal   (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Wait for IDLE, present one request, leave the bench just after the accept edge.
    task automatic start(input logic [31:0] a, input logic [31:0] b,
                         input logic un, input logic [2:0] op);
        int n = 0;
        @(negedge clk);
        while (!o_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_issue", 32'(o_ready), 32'd1);
        i_valid    = 1'b1;
        i_rs1_data = a;
        i_rs2_data = b;
        i_br_un    = un;
        i_br_op    = op;
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        for (int i = 0; i < 20 && !o_valid; i++) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic un, input logic [2:0] op, input int exp_lat,
                       input logic e_less, input logic e_eq, input logic e_tk, input logic e_ill);
        int lat;
        start(a, b, un, op);
        wait_valid(lat);
        chk({tag, "_lat"},     32'(lat),         32'(exp_lat));
        chk({tag, "_valid"},   32'(o_valid),     32'd1);
        chk({tag, "_less"},    32'(o_brc_less),  32'(e_less));
        chk({tag, "_equal"},   32'(o_brc_equal), 32'(e_eq));
        chk({tag, "_taken"},   32'(o_br_taken),  32'(e_tk));
        chk({tag, "_illegal"}, 32'(o_illegal),   32'(e_ill));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic seen;
        rst_n      = 1'b0;
        i_valid    = 1'b0;
        i_br_un    = 1'b0;
        i_br_op    = 3'b000;
        i_rs1_data = '0;
        i_rs2_data = '0;
        i_flush    = 1'b0;
        i_ready    = 1'b1;

        #1;
        chk("rst_valid", 32'(o_valid),     32'd0);
        chk("rst_less",  32'(o_brc_less),  32'd0);
        chk("rst_equal", 32'(o_brc_equal), 32'd0);
        chk("rst_taken", 32'(o_br_taken),  32'd0);
        chk("rst_ill",   32'(o_illegal),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_ready", 32'(o_ready), 32'd1);

        run("beq_eq",      32'h12345678, 32'h12345678, 1'b1, 3'b000, 4, 1'b0, 1'b1, 1'b1, 1'b0);
        run("blt_signed",  32'hFFFFFFFF, 32'h00000001, 1'b1, 3'b100, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        run("blt_unsign",  32'hFFFFFFFF, 32'h00000001, 1'b0, 3'b100, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("bne_mid",     32'h12345678, 32'h12355678, 1'b0, 3'b001, 2, 1'b1, 1'b0, 1'b1, 1'b0);
        run("bge_signed",  32'h80000000, 32'h7FFFFFFF, 1'b1, 3'b101, 1, 1'b1, 1'b0, 1'b0, 1'b0);
        run("bltu_unsign", 32'h80000000, 32'h7FFFFFFF, 1'b0, 3'b110, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        run("bltu_signed", 32'h80000000, 32'h00000001, 1'b1, 3'b110, 1, 1'b1, 1'b0, 1'b1, 1'b0);
        run("bgeu_low",    32'h00000005, 32'h00000007, 1'b0, 3'b111, 4, 1'b1, 1'b0, 1'b0, 1'b0);

        // Flush in the second CMP cycle; previous result (less=1, equal=0) must persist.
        start(32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 3'b000);
        @(posedge clk);
        #1 i_flush = 1'b1;
        @(posedge clk);
        #1 i_flush = 1'b0;
        chk("flush_valid", 32'(o_valid), 32'd0);
        chk("flush_ready", 32'(o_ready), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 if (o_valid) seen = 1'b1;
        end
        chk("flush_no_valid", 32'(seen),        32'd0);
        chk("flush_equal",    32'(o_brc_equal), 32'd0);
        chk("flush_less",     32'(o_brc_less),  32'd1);

        // Backpressure in DONE while a new request is offered.
        i_ready = 1'b0;
        start(32'h00000005, 32'h00000005, 1'b0, 3'b000);
        wait_valid(lat);
        chk("bp_lat", 32'(lat), 32'd4);
        @(negedge clk);
        i_valid    = 1'b1;
        i_rs1_data = 32'h1;
        i_rs2_data = 32'h2;
        i_br_op    = 3'b100;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("bp_valid", 32'(o_valid),     32'd1);
            chk("bp_ready", 32'(o_ready),     32'd0);
            chk("bp_equal", 32'(o_brc_equal), 32'd1);
            chk("bp_less",  32'(o_brc_less),  32'd0);
            chk("bp_taken", 32'(o_br_taken),  32'd1);
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(o_valid), 32'd0);
        chk("bp_release_ready", 32'(o_ready), 32'd1);
        i_valid = 1'b0;
        @(posedge clk);
        #1 chk("bp_no_accept", 32'(o_ready), 32'd1);

        run("illegal_010", 32'h00000001, 32'h00000002, 1'b0, 3'b010, 4, 1'b1, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of CMP.
        start(32'h77777777, 32'h77777777, 1'b0, 3'b100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid),   32'd0);
        chk("arst_less",  32'(o_brc_less), 32'd0);
        chk("arst_ill",   32'(o_illegal), 32'd0);
        chk("arst_ready", 32'(o_ready),   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("arst_ready_after", 32'(o_ready), 32'd1);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1 if (o_valid) seen = 1'b1;
        end
        chk("arst_no_valid", 32'(seen), 32'd0);

        run("post_rst_beq", 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 3'b000, 4, 1'b0, 1'b1, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/brc_seq.md
BRC_SEQ -- requirements
Module: brc_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits; legal values are multiples of CHUNK and at least 8.
REQ-002 SHALL have parameter CHUNK, default 8, bits compared per cycle; it SHALL divide WIDTH exactly; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have one clock and an asynchronous, active-low reset, named i_clk and i_rst_n.
REQ-004 SHALL have ports:
  i_clk  in  1  clock, rising edge.
  i_rst_n  in  1  asynchronous reset, active low.
  i_valid  in  1  request valid.
  o_ready  out  1  request accept; high only in IDLE.
  i_br_un  in  1  compare mode: 1 signed, 0 unsigned.
  i_br_op  in  3  branch funct3.
  i_rs1_data  in  WIDTH  operand A.
  i_rs2_data  in  WIDTH  operand B.
  i_flush  in  1  synchronous abort.
  o_valid  out  1  result valid.
  i_ready  in  1  result consumed.
  o_brc_less  out  1  A < B under the captured mode.
  o_brc_equal  out  1  A == B.
  o_br_taken  out  1  branch decision.
  o_illegal  out  1  captured i_br_op is unsupported.

Function
REQ-005 SHALL implement FSM states IDLE, CMP and DONE.
REQ-006 A request SHALL be accepted at a rising edge where i_valid=1, o_ready=1 and i_flush=0.
REQ-007 On accept, the block SHALL register the operands, i_br_un and i_br_op, set chunk index k=NCHUNK-1, and enter CMP.
REQ-008 i_valid and the input data SHALL be ignored outside IDLE.
REQ-009 In CMP, the block SHALL compare chunk k of A and B each cycle, MSB chunk first.
REQ-010 For the top chunk in signed mode, the comparison SHALL invert the MSB of both operand chunks before the unsigned chunk compare; all other chunks, and all chunks in unsigned mode, are compared unsigned.
REQ-011 When chunks differ: less = (A chunk < B chunk), equal = 0, and the FSM enters DONE at the next edge (early termination).
REQ-012 When chunks match and k>0: k decrements and the FSM stays in CMP.
REQ-013 When chunks match and k=0: less = 0, equal = 1, and the FSM enters DONE.
REQ-014 Latency SHALL equal L cycles from the accepting edge to o_valid=1, where L = number of chunks examined (1..NCHUNK).
REQ-015 o_valid SHALL be high exactly in DONE.
REQ-016 o_brc_less, o_brc_equal, o_br_taken and o_illegal SHALL be registered, and SHALL be held stable while o_valid=1 and i_ready=0.
REQ-017 In DONE with i_ready=1, the FSM SHALL return to IDLE at the next edge; no accept occurs in that same cycle, so the minimum issue interval is L+2 cycles.
REQ-018 Taken decode SHALL be: 000 BEQ = equal; 001 BNE = ~equal; 100 BLT and 110 BLTU = less; 101 BGE and 111 BGEU = ~less.
REQ-019 Signedness SHALL come only from i_br_un; i_br_op selects only the predicate.
REQ-020 i_br_op 010 or 011 SHALL give o_br_taken=0 and o_illegal=1; the comparison itself still completes normally.
REQ-021 i_flush=1 in any state SHALL force IDLE at the next edge, with o_valid=0 and result registers unchanged.
REQ-022 i_flush SHALL have priority over accept and over the DONE release.
REQ-023 In any state other than DONE, o_ready SHALL equal (state==IDLE).

Reset
REQ-024 Asserting i_rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, k=NCHUNK-1, o_valid=0, o_brc_less=0, o_brc_equal=0, o_br_taken=0, o_illegal=0 and all captured-operand registers to 0.
REQ-025 Reset asserted mid-CMP or in DONE SHALL discard the operation; no o_valid follows.
REQ-026 After deassertion, o_ready SHALL be 1 in the first cycle.

Verification (WIDTH=32, CHUNK=8)
REQ-027 A=0x12345678, B=0x12345678, i_br_un=1, op 000 -> o_valid 4 cycles after accept; equal=1, less=0, taken=1.
REQ-028 A=0xFFFFFFFF, B=0x00000001, op 100 -> i_br_un=1: o_valid after 1 cycle, less=1, taken=1; repeated with i_br_un=0: less=0, taken=0, also after 1 cycle.
REQ-029 A=0x00000005, B=0x00000007, i_br_un=0, op 111 -> o_valid after 4 cycles; less=1, equal=0, taken=0.
REQ-030 Backpressure: i_ready=0 for 3 cycles in DONE while i_valid=1 with new data -> outputs unchanged, o_ready=0, no second accept; then i_ready=1 -> IDLE next cycle, o_ready=1.
REQ-031 Abort: i_flush=1 in the 2nd CMP cycle of an equal-operand request -> IDLE next edge, o_valid never rises; i_rst_n pulsed low mid-CMP -> o_valid=0 and outputs 0 asynchronously.
REQ-032 Illegal op: A=1, B=2, op 010 -> o_illegal=1, taken=0, less=1 after 4 cycles.
